// File: rtl/game_pkg.sv
// Types and constants shared by the game-object controllers.
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam int          OBSTACLE_WIDTH = 50;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;
endpackage

// File: rtl/vga_pkg.sv
// Video timing constants for the 800x600 display that the game objects are placed on.
package vga_pkg;
  localparam logic [11:0] HOR_PIXELS = 12'd800;
  localparam logic [11:0] VER_PIXELS = 12'd600;
endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, loaded with seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] state
);
  logic [15:0] lfsr_q, lfsr_d;
  logic        feedback;

  // The zero check only matters if the register is somehow upset into the lock-up state.
  always_comb begin
    feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = {feedback, lfsr_q[15:1]};
    if (lfsr_d == 16'h0000) lfsr_d = seed;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;
endmodule

// File: rtl/obstacle_ctl.sv
// Obstacle column controller: scrolls a gapped obstacle left each frame and respawns it
// at a pseudo-random height once it leaves the screen.
module obstacle_ctl
  import vga_pkg::*, game_pkg::*;
#(
  parameter int SPEED = 4,
  parameter int GAP_H = 150,
  parameter int Y_MIN = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        halt,
  output logic [11:0] obstacle_xpos_1,
  output logic [11:0] obstacle_ypos_1,
  output logic [11:0] obstacle_ypos_2,
  output logic        obstacle_passed,
  output logic        running
);
  localparam logic [11:0] SPEED_W = 12'(SPEED);
  localparam logic [11:0] GAP_W   = 12'(GAP_H);
  localparam logic [11:0] Y_MIN_W = 12'(Y_MIN);

  state_t      state_q, state_d;
  logic [11:0] xpos_q, xpos_d, ypos1_q, ypos1_d, ypos2_q, ypos2_d;
  logic        passed_q, passed_d, running_q, running_d;
  logic        spawn;
  logic [15:0] lfsr_state;
  logic [11:0] spawn_y1, spawn_y2;
  logic        unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .state(lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[15:8];
  assign spawn_y1       = Y_MIN_W + {4'b0000, lfsr_state[7:0]};
  assign spawn_y2       = spawn_y1 + GAP_W;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // halt wins over start everywhere, so a frozen game cannot resume while still colliding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start && !halt) state_d = ST_RUN;
      ST_RUN:    if (halt)           state_d = ST_FROZEN;
      ST_FROZEN: if (start && !halt) state_d = ST_RUN;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    xpos_d   = xpos_q;
    ypos1_d  = ypos1_q;
    ypos2_d  = ypos2_q;
    passed_d = 1'b0;
    spawn    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_RUN) begin
          spawn = 1'b1;
        end else begin
          xpos_d  = HOR_PIXELS;
          ypos1_d = 12'd0;
          ypos2_d = VER_PIXELS - 12'd1;
        end
      end
      ST_RUN: begin
        if (!halt && frame_tick) begin
          if (xpos_q >= SPEED_W) begin
            xpos_d = xpos_q - SPEED_W;
          end else begin
            spawn    = 1'b1;
            passed_d = 1'b1;
          end
        end
      end
      ST_FROZEN: if (state_d == ST_RUN) spawn = 1'b1;
      default: ;
    endcase
    if (spawn) begin
      xpos_d  = HOR_PIXELS - 12'd1;
      ypos1_d = spawn_y1;
      ypos2_d = spawn_y2;
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q    <= HOR_PIXELS;
      ypos1_q   <= 12'd0;
      ypos2_q   <= VER_PIXELS - 12'd1;
      passed_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      xpos_q    <= xpos_d;
      ypos1_q   <= ypos1_d;
      ypos2_q   <= ypos2_d;
      passed_q  <= passed_d;
      running_q <= running_d;
    end
  end

  assign obstacle_xpos_1 = xpos_q;
  assign obstacle_ypos_1 = ypos1_q;
  assign obstacle_ypos_2 = ypos2_q;
  assign obstacle_passed = passed_q;
  assign running         = running_q;
endmodule

// File: tb/tb_obstacle_ctl.sv
// Directed plus randomized-invariant bench for obstacle_ctl with default parameters.
module tb_obstacle_ctl;
  localparam int HOR = 800;
  localparam int VER = 600;
  localparam int YMIN = 100;
  localparam int GAP = 150;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [11:0] xpos, ypos1, ypos2;
  logic        passed, running;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] lfsr_m;
  int          exp_y;
  int          seen_passed;
  int          prev_x;
  logic        prev_event;

  obstacle_ctl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .start          (start),
    .halt           (halt),
    .obstacle_xpos_1(xpos),
    .obstacle_ypos_1(ypos1),
    .obstacle_ypos_2(ypos2),
    .obstacle_passed(passed),
    .running        (running)
  );

  always #5 clk = ~clk;

  // Reference LFSR for x^16+x^14+x^13+x^11+1 (taps on bits 0,2,3,5 of a right shift).
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    seen_passed += int'(passed);
    cycle();
    seen_passed += int'(passed);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_x", int'(xpos), HOR);
    chk("reset_y1", int'(ypos1), 0);
    chk("reset_y2", int'(ypos2), VER - 1);
    chk("reset_running", int'(running), 0);
    chk("reset_passed", int'(passed), 0);

    seen_passed = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_x", int'(xpos), HOR);
    chk("idle_y1", int'(ypos1), 0);
    chk("idle_y2", int'(ypos2), VER - 1);
    chk("idle_running", int'(running), 0);
    chk("idle_passed", seen_passed, 0);

    exp_y = YMIN + int'(lfsr_m[7:0]);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("start_running", int'(running), 1);
    chk("start_x", int'(xpos), HOR - 1);
    chk("start_y1", int'(ypos1), exp_y);
    chk("start_y2", int'(ypos2), exp_y + GAP);
    chk("start_passed", int'(passed), 0);

    for (int i = 0; i < 5; i++) tick();
    chk("move5_x", int'(xpos), HOR - 1 - 20);
    chk("move5_gap", int'(ypos2) - int'(ypos1), GAP);
    chk("move5_ymin", int'(ypos1 >= 12'(YMIN) && ypos1 <= 12'(YMIN + 255)), 1);

    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    chk("start_in_run_x", int'(xpos), HOR - 1 - 20);
    chk("start_in_run_y1", int'(ypos1), exp_y);

    seen_passed = 0;
    for (int i = 0; i < 194; i++) tick();
    chk("edge_x", int'(xpos), 3);
    chk("edge_no_passed", seen_passed, 0);

    exp_y = YMIN + int'(lfsr_m[7:0]);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("wrap_passed", int'(passed), 1);
    chk("wrap_x", int'(xpos), HOR - 1);
    chk("wrap_y1", int'(ypos1), exp_y);
    chk("wrap_y2", int'(ypos2), exp_y + GAP);
    cycle();
    chk("wrap_passed_drop", int'(passed), 0);

    tick();
    tick();
    chk("pre_halt_x", int'(xpos), HOR - 1 - 8);
    halt = 1'b1;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("halt_running", int'(running), 0);
    chk("halt_x", int'(xpos), HOR - 1 - 8);
    chk("halt_y1", int'(ypos1), exp_y);
    halt = 1'b0;
    tick();
    chk("frozen_tick_x", int'(xpos), HOR - 1 - 8);
    chk("frozen_passed", int'(passed), 0);
    halt = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    halt = 1'b0;
    chk("start_halt_frozen", int'(running), 0);
    chk("start_halt_x", int'(xpos), HOR - 1 - 8);

    exp_y = YMIN + int'(lfsr_m[7:0]);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("resume_running", int'(running), 1);
    chk("resume_x", int'(xpos), HOR - 1);
    chk("resume_y1", int'(ypos1), exp_y);
    chk("resume_y2", int'(ypos2), exp_y + GAP);

    halt = 1'b1;
    cycle();
    halt = 1'b0;
    chk("refreeze_running", int'(running), 0);
    rst = 1'b1;
    start = 1'b1;
    cycle();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_frozen_x", int'(xpos), HOR);
    chk("rst_frozen_y1", int'(ypos1), 0);
    chk("rst_frozen_y2", int'(ypos2), VER - 1);
    chk("rst_frozen_running", int'(running), 0);
    chk("rst_frozen_lfsr", int'(dut.u_lfsr.state), 16'hACE1);

    for (int i = 0; i < 20000; i++) begin
      start      = ($urandom_range(0, 31) == 0);
      halt       = ($urandom_range(0, 15) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      prev_x     = int'(xpos);
      prev_event = frame_tick | start;
      cycle();
      chk("rand_lfsr_nonzero", int'(dut.u_lfsr.state != 16'h0000), 1);
      chk("rand_lfsr_model", int'(dut.u_lfsr.state), int'(lfsr_m));
      chk("rand_y2_range", int'(ypos2 < 12'(VER)), 1);
      if (int'(xpos) != prev_x) begin
        chk("rand_x_cause", int'(prev_event), 1);
        chk("rand_x_step", int'(int'(xpos) == prev_x - 4 || int'(xpos) == HOR - 1), 1);
      end
    end
    start      = 1'b0;
    halt       = 1'b0;
    frame_tick = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
